// File: rtl/core_ex_muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide, BITS_PER_CYCLE bits per cycle.
module core_ex_muldiv_iter #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o,
  output logic            busy_o
);

  localparam int ITER = XLEN / BITS_PER_CYCLE;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]      r_f3;
  logic [4:0]      r_rd;
  logic            r_neg;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_m;
  logic [CW-1:0]   r_cnt;

  logic            w_acc;
  logic            w_div;
  logic            w_sa;
  logic            w_sb;
  logic            w_an;
  logic            w_bn;
  logic            w_bz;
  logic            w_ovf;
  logic            w_fast;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;

  logic [XLEN-1:0] w_hi;
  logic [XLEN-1:0] w_lo;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_t;

  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_q;
  logic [XLEN-1:0]   w_r;
  logic [XLEN-1:0]   w_res;

  assign w_acc = valid_i && ready_o;
  assign w_div = funct3_i[2];
  assign w_sa  = (funct3_i == 3'd1) || (funct3_i == 3'd2) ||
                 (funct3_i == 3'd4) || (funct3_i == 3'd6);
  assign w_sb  = (funct3_i == 3'd1) || (funct3_i == 3'd4) ||
                 (funct3_i == 3'd6);
  assign w_an  = w_sa && op_a_i[XLEN-1];
  assign w_bn  = w_sb && op_b_i[XLEN-1];
  assign w_abs_a = w_an ? -op_a_i : op_a_i;
  assign w_abs_b = w_bn ? -op_b_i : op_b_i;
  assign w_bz  = (op_b_i == '0);
  assign w_ovf = w_div && !funct3_i[0] &&
                 (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                 (op_b_i == '1);
  assign w_fast = w_div && (w_bz || w_ovf);

  always_comb begin
    w_next  = r_state;
    ready_o = (r_state == S_IDLE) && !flush_i;
    busy_o  = (r_state != S_IDLE);
    valid_o = (r_state == S_DONE);
    case (r_state)
      S_IDLE: if (w_acc) w_next = w_fast ? S_FIX : S_CALC;
      S_CALC: if (r_cnt == CW'(1)) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: if (ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush_i) w_next = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // r_hi:r_lo is product accumulator for multiply, remainder:quotient for divide
  always_comb begin
    w_hi  = r_hi;
    w_lo  = r_lo;
    w_sum = '0;
    w_t   = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (!r_f3[2]) begin
        w_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_m} : '0);
        w_lo  = {w_sum[0], w_lo[XLEN-1:1]};
        w_hi  = w_sum[XLEN:1];
      end else begin
        w_t  = {w_hi, w_lo[XLEN-1]};
        w_lo = {w_lo[XLEN-2:0], 1'b0};
        if (w_t >= {1'b0, r_m}) begin
          w_t     = w_t - {1'b0, r_m};
          w_lo[0] = 1'b1;
        end
        w_hi = w_t[XLEN-1:0];
      end
    end
  end

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = r_neg ? -w_prod : w_prod;
  assign w_q      = r_neg ? -r_lo : r_lo;
  assign w_r      = r_neg ? -r_hi : r_hi;

  always_comb begin
    w_res = '0;
    unique case (1'b1)
      (r_f3 == 3'd0):              w_res = w_prod_s[XLEN-1:0];
      (!r_f3[2] && r_f3 != 3'd0):  w_res = w_prod_s[2*XLEN-1:XLEN];
      (r_f3[2] && !r_f3[1]):       w_res = w_q;
      (r_f3[2] && r_f3[1]):        w_res = w_r;
      default:                     w_res = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_f3     <= '0;
      r_rd     <= '0;
      r_neg    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_m      <= '0;
      r_cnt    <= '0;
      result_o <= '0;
      rd_o     <= '0;
    end else begin
      if (w_acc) begin
        r_f3  <= funct3_i;
        r_rd  <= rd_i;
        r_cnt <= CW'(ITER);
        r_m   <= w_div ? w_abs_b : w_abs_a;
        r_hi  <= '0;
        r_lo  <= w_div ? w_abs_a : w_abs_b;
        r_neg <= (funct3_i == 3'd6) ? w_an : (w_an ^ w_bn);
        // fast paths preload the raw answers so FIX passes them through
        if (w_div && w_bz) begin
          r_lo  <= '1;
          r_hi  <= op_a_i;
          r_neg <= 1'b0;
        end else if (w_ovf) begin
          r_lo  <= op_a_i;
          r_hi  <= '0;
          r_neg <= 1'b0;
        end
      end else if (r_state == S_CALC) begin
        r_hi  <= w_hi;
        r_lo  <= w_lo;
        r_cnt <= r_cnt - 1'b1;
      end
      if (r_state == S_FIX && !flush_i) begin
        result_o <= w_res;
        rd_o     <= r_rd;
      end
    end
  end

endmodule

// File: tb/tb_core_ex_muldiv_iter.sv
// Scoreboard bench for core_ex_muldiv_iter at BITS_PER_CYCLE 1, 2 and 4.
// Expected results come from native 64-bit arithmetic.
module tb_core_ex_muldiv_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  f3;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rd;
  logic        flush;
  logic        rdy;
  logic        rdy_hi;
  logic        v1, v2, v4;

  logic        rdy1, val1, busy1;
  logic [31:0] res1;
  logic [4:0]  rdo1;
  logic        rdy2, val2, busy2;
  logic [31:0] res2;
  logic [4:0]  rdo2;
  logic        rdy4, val4, busy4;
  logic [31:0] res4;
  logic [4:0]  rdo4;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [36:0] q1[$];
  logic [36:0] q2[$];
  logic [36:0] q4[$];
  logic [36:0] e1, e2, e4;

  core_ex_muldiv_iter #(.XLEN(32), .BITS_PER_CYCLE(1)) u1 (
    .clk_i(clk), .rst_i(rst), .valid_i(v1), .ready_o(rdy1),
    .funct3_i(f3), .op_a_i(a), .op_b_i(b), .rd_i(rd),
    .flush_i(flush), .valid_o(val1), .ready_i(rdy),
    .result_o(res1), .rd_o(rdo1), .busy_o(busy1));

  core_ex_muldiv_iter #(.XLEN(32), .BITS_PER_CYCLE(2)) u2 (
    .clk_i(clk), .rst_i(rst), .valid_i(v2), .ready_o(rdy2),
    .funct3_i(f3), .op_a_i(a), .op_b_i(b), .rd_i(rd),
    .flush_i(flush), .valid_o(val2), .ready_i(rdy_hi),
    .result_o(res2), .rd_o(rdo2), .busy_o(busy2));

  core_ex_muldiv_iter #(.XLEN(32), .BITS_PER_CYCLE(4)) u4 (
    .clk_i(clk), .rst_i(rst), .valid_i(v4), .ready_o(rdy4),
    .funct3_i(f3), .op_a_i(a), .op_b_i(b), .rd_i(rd),
    .flush_i(flush), .valid_o(val4), .ready_i(rdy_hi),
    .result_o(res4), .rd_o(rdo4), .busy_o(busy4));

  always @(negedge clk) begin
    if (!rst && val1 && rdy) begin
      n_tests++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL sb_u1 unexpected: rd=%0d res=%h, want none",
                 rdo1, res1);
      end else begin
        e1 = q1.pop_front();
        if ({rdo1, res1} !== e1) begin
          n_fail++;
          $display("FAIL sb_u1: rd=%0d res=%h, want rd=%0d res=%h",
                   rdo1, res1, e1[36:32], e1[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && val2 && rdy_hi) begin
      n_tests++;
      if (q2.size() == 0) begin
        n_fail++;
        $display("FAIL sb_u2 unexpected: res=%h, want none", res2);
      end else begin
        e2 = q2.pop_front();
        if ({rdo2, res2} !== e2) begin
          n_fail++;
          $display("FAIL sb_u2: rd=%0d res=%h, want rd=%0d res=%h",
                   rdo2, res2, e2[36:32], e2[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && val4 && rdy_hi) begin
      n_tests++;
      if (q4.size() == 0) begin
        n_fail++;
        $display("FAIL sb_u4 unexpected: res=%h, want none", res4);
      end else begin
        e4 = q4.pop_front();
        if ({rdo4, res4} !== e4) begin
          n_fail++;
          $display("FAIL sb_u4: rd=%0d res=%h, want rd=%0d res=%h",
                   rdo4, res4, e4[36:32], e4[31:0]);
        end
      end
    end
  end

  function automatic logic [31:0] ref_model(
    input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xs, xu, ys, yu, p;
    logic signed [31:0] sx, sy;
    logic ovf;
    xs = {{32{x[31]}}, x};
    xu = {32'h0, x};
    ys = {{32{y[31]}}, y};
    yu = {32'h0, y};
    sx = x;
    sy = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = xu * yu; return p[31:0]; end
      3'd1: begin p = xs * ys; return p[63:32]; end
      3'd2: begin p = xs * yu; return p[63:32]; end
      3'd3: begin p = xu * yu; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return x;
        return sx / sy;
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (ovf) return 32'h0;
        return sx % sy;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic logic inst_ready(input int s);
    case (s)
      2: return rdy2;
      4: return rdy4;
      default: return rdy1;
    endcase
  endfunction

  function automatic logic inst_valid(input int s);
    case (s)
      2: return val2;
      4: return val4;
      default: return val1;
    endcase
  endfunction

  function automatic logic inst_busy(input int s);
    case (s)
      2: return busy2;
      4: return busy4;
      default: return busy1;
    endcase
  endfunction

  task automatic set_valid(input int s, input logic v);
    case (s)
      2: v2 = v;
      4: v4 = v;
      default: v1 = v;
    endcase
  endtask

  task automatic issue(input int s, input logic [2:0] f,
                       input logic [31:0] aa, input logic [31:0] bb,
                       input logic [4:0] r, input bit push,
                       output int unsigned acc);
    logic [31:0] ex;
    bit ok;
    ex = ref_model(f, aa, bb);
    if (push) begin
      case (s)
        2: q2.push_back({r, ex});
        4: q4.push_back({r, ex});
        default: q1.push_back({r, ex});
      endcase
    end
    @(posedge clk);
    #1;
    f3 = f; a = aa; b = bb; rd = r;
    set_valid(s, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (inst_ready(s)) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    acc = cyc;
    set_valid(s, 1'b0);
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout u%0d: ready_o=0, want 1", s);
    end
  endtask

  task automatic wait_valid(input int s, input int unsigned acc,
                            output int lat, output bit busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (inst_valid(s)) begin
        lat = int'(cyc - acc) + 1;
        break;
      end
      if (!inst_busy(s)) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; rdy = 1'b1;
    v1 = 1'b0; v2 = 1'b0; v4 = 1'b0;
    f3 = '0; a = '0; b = '0; rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({rdy1, val1, busy1} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_ctl: rdy/val/busy=%b, want 100",
               {rdy1, val1, busy1});
    end
    n_tests++;
    if ({rdo1, res1} !== 37'h0) begin
      n_fail++;
      $display("FAIL reset_data: rd=%0d res=%h, want 0", rdo1, res1);
    end
    n_tests++;
    if ({rdy2, rdy4, val2, val4} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_bpc: %b, want 1100",
               {rdy2, rdy4, val2, val4});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_mul;
    int unsigned acc;
    int lat;
    bit bok;
    logic [2:0]  tf[4]  = '{3'd0, 3'd1, 3'd3, 3'd2};
    logic [31:0] ta[4]  = '{32'd7, 32'h8000_0000, 32'h8000_0000,
                            32'hFFFF_FFFF};
    logic [31:0] tb_[4] = '{32'hFFFF_FFFD, 32'h8000_0000,
                            32'h8000_0000, 32'd2};
    for (int i = 0; i < 4; i++) begin
      issue(1, tf[i], ta[i], tb_[i], 5'(i + 1), 1'b1, acc);
      wait_valid(1, acc, lat, bok);
      n_tests++;
      if (lat !== 34) begin
        n_fail++;
        $display("FAIL mul_lat[%0d]: %0d, want 34", i, lat);
      end
      n_tests++;
      if (bok !== 1'b1) begin
        n_fail++;
        $display("FAIL mul_busy[%0d]: busy dropped, want high", i);
      end
    end
    @(negedge clk);
    n_tests++;
    if (busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_busy_end: %b, want 0", busy1);
    end
  endtask

  task automatic test_random;
    int unsigned acc;
    int lat, want;
    bit bok;
    logic [2:0]  f;
    logic [31:0] x, y;
    for (int i = 0; i < 8; i++) begin
      f = 3'(i);
      x = $urandom;
      y = (i == 6) ? 32'h0 : $urandom;
      if (i == 5) y = y >> 20;
      want = (f[2] && y == 0) ? 2 : 34;
      issue(1, f, x, y, 5'(i + 8), 1'b1, acc);
      wait_valid(1, acc, lat, bok);
      n_tests++;
      if (lat !== want) begin
        n_fail++;
        $display("FAIL rand_lat[%0d]: %0d, want %0d", i, lat, want);
      end
    end
  endtask

  task automatic test_div;
    int unsigned acc;
    int lat;
    bit bok;
    for (int i = 0; i < 2; i++) begin
      issue(1, (i == 0) ? 3'd4 : 3'd6, 32'hFFFF_FFF9, 32'd2,
            5'(20 + i), 1'b1, acc);
      wait_valid(1, acc, lat, bok);
      n_tests++;
      if (lat !== 34) begin
        n_fail++;
        $display("FAIL div_lat[%0d]: %0d, want 34", i, lat);
      end
    end
  endtask

  task automatic test_fast;
    int unsigned acc;
    int lat;
    bit bok;
    logic [2:0]  tf[4]  = '{3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] ta[4]  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] tb_[4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      issue(1, tf[i], ta[i], tb_[i], 5'(24 + i), 1'b1, acc);
      wait_valid(1, acc, lat, bok);
      n_tests++;
      if (lat !== 2) begin
        n_fail++;
        $display("FAIL fast_lat[%0d]: %0d, want 2", i, lat);
      end
    end
  endtask

  task automatic test_bpc;
    int unsigned acc;
    int lat, want;
    bit bok;
    logic [2:0] tf[3] = '{3'd4, 3'd6, 3'd0};
    logic [31:0] ta[3] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7};
    logic [31:0] tb_[3] = '{32'd2, 32'd2, 32'hFFFF_FFFD};
    for (int s = 2; s <= 4; s += 2) begin
      want = (s == 2) ? 18 : 10;
      for (int i = 0; i < 3; i++) begin
        issue(s, tf[i], ta[i], tb_[i], 5'(s + i), 1'b1, acc);
        wait_valid(s, acc, lat, bok);
        n_tests++;
        if (lat !== want) begin
          n_fail++;
          $display("FAIL bpc%0d_lat[%0d]: %0d, want %0d",
                   s, i, lat, want);
        end
      end
    end
  endtask

  task automatic test_flush;
    int unsigned acc;
    int lat;
    bit bok, seen;
    issue(1, 3'd0, 32'd3, 32'd5, 5'd3, 1'b0, acc);
    repeat (8) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_pre_busy: %b, want 1", busy1);
    end
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({rdy1, val1, busy1} !== 3'b100) begin
      n_fail++;
      $display("FAIL flush_calc: rdy/val/busy=%b, want 100",
               {rdy1, val1, busy1});
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (val1) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_no_result: valid seen, want none");
    end
    @(posedge clk); #1;
    v1 = 1'b1; flush = 1'b1; f3 = 3'd0; a = 32'd1; b = 32'd1;
    @(negedge clk);
    n_tests++;
    if (rdy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ready: %b, want 0", rdy1);
    end
    @(posedge clk); #1;
    v1 = 1'b0; flush = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_no_accept: busy=%b, want 0", busy1);
    end
    rdy = 1'b0;
    issue(1, 3'd5, 32'd5, 32'd0, 5'd17, 1'b0, acc);
    wait_valid(1, acc, lat, bok);
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0; rdy = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({val1, busy1} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_done: val/busy=%b, want 00", {val1, busy1});
    end
  endtask

  task automatic test_reset_mid;
    int unsigned acc;
    issue(1, 3'd3, 32'h1234_5678, 32'd9, 5'd6, 1'b0, acc);
    repeat (4) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({rdy1, val1, busy1} !== 3'b100) begin
      n_fail++;
      $display("FAIL rst_mid_ctl: rdy/val/busy=%b, want 100",
               {rdy1, val1, busy1});
    end
    n_tests++;
    if ({rdo1, res1} !== 37'h0) begin
      n_fail++;
      $display("FAIL rst_mid_data: rd=%0d res=%h, want 0", rdo1, res1);
    end
  endtask

  task automatic test_back_to_back;
    int unsigned acc;
    int lat;
    bit bok;
    logic [31:0] r0;
    logic [4:0]  d0;
    rdy = 1'b0;
    issue(1, 3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd9, 1'b1, acc);
    wait_valid(1, acc, lat, bok);
    r0 = res1;
    d0 = rdo1;
    q1.push_back({5'd10, ref_model(3'd5, 32'd100, 32'd7)});
    @(posedge clk); #1;
    v1 = 1'b1; f3 = 3'd5; a = 32'd100; b = 32'd7; rd = 5'd10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if ({val1, rdy1, rdo1, res1} !== {2'b10, d0, r0}) begin
        n_fail++;
        $display("FAIL hold[%0d]: val=%b rdy=%b rd=%0d res=%h, want 1 0 %0d %h",
                 i, val1, rdy1, rdo1, res1, d0, r0);
      end
    end
    @(posedge clk); #1; rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy1, rdy1} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_idle: busy/rdy=%b, want 01", {busy1, rdy1});
    end
    @(posedge clk); #1;
    acc = cyc;
    v1 = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b, want 1", busy1);
    end
    wait_valid(1, acc, lat, bok);
    n_tests++;
    if (lat !== 34) begin
      n_fail++;
      $display("FAIL b2b_lat: %0d, want 34", lat);
    end
  endtask

  initial begin
    rdy_hi = 1'b1;
    test_reset();
    test_mul();
    test_div();
    test_fast();
    test_random();
    test_bpc();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    for (int i = 0; i < 100; i++) begin
      if (q1.size() == 0 && q2.size() == 0 && q4.size() == 0) break;
      @(negedge clk);
    end
    n_tests++;
    if (q1.size() + q2.size() + q4.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d pending, want 0",
               q1.size() + q2.size() + q4.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_ex_muldiv_iter.md
Name: core_ex_muldiv_iter

Overview:
Parametrised iterative multiply/divide unit for the EX stage. It executes all eight RV32M/RV64M operations over multiple cycles, processing BITS_PER_CYCLE bits per cycle. It uses valid/ready handshakes on both sides and drives a busy output that the pipeline uses to stall EX. Operands arrive already forwarded from the EX operand muxes.

Parameters:
XLEN, 32, operand/result width; legal values 32 or 64
BITS_PER_CYCLE, 1, bits retired per iteration; legal values 1, 2, 4; must divide XLEN
ITER (localparam), XLEN/BITS_PER_CYCLE, iteration count

Ports:
clk_i  in  1  clock
rst_i  in  1  reset: synchronous, active-high
valid_i  in  1  operation request
ready_o  out  1  unit can accept a request
funct3_i  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
op_a_i  in  XLEN  rs1 operand (multiplicand/dividend)
op_b_i  in  XLEN  rs2 operand (multiplier/divisor)
rd_i  in  5  destination register tag
flush_i  in  1  kill in-flight operation (branch taken/exception)
valid_o  out  1  result available
ready_i  in  1  consumer accepts result
result_o  out  XLEN  result
rd_o  out  5  tag of the result
busy_o  out  1  unit occupied; used for EX stall

Behaviour:
- States: IDLE, CALC, FIX, DONE.
- Reset: state IDLE; valid_o, busy_o, result_o, rd_o all 0; ready_o 1. Reset takes priority over flush and over every other event, and aborts any in-flight operation.
- ready_o = (state==IDLE) && !flush_i.
- busy_o = (state!=IDLE).
- Accept: at the edge where valid_i && ready_o. Latch funct3, rd, operand absolute values and result-sign flags. Load the counter with ITER.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: op_a signed, op_b unsigned.
  - MUL/MULHU/DIVU/REMU: operands unsigned. MUL low half is sign-agnostic.
  - DIV/REM: both operands signed. Remainder sign follows the dividend.
- CALC, multiply: shift-add on a 2*XLEN accumulator, BITS_PER_CYCLE multiplier bits per cycle.
- CALC, divide: restoring divide, BITS_PER_CYCLE quotient bits per cycle.
- Counter decrements once per CALC cycle. At counter==1, go to FIX.
- FIX (1 cycle): conditionally negate the product/quotient/remainder. Select the low XLEN bits (MUL/DIV/REM) or the high XLEN bits (MULH*) of the product. Register result_o and rd_o, then go to DONE.
- DONE: valid_o=1. result_o and rd_o stay stable while ready_i=0. On ready_i=1, go to IDLE and drop valid_o next cycle.
- Back-to-back: at least one IDLE cycle separates operations; no same-cycle re-accept from DONE.
- Latency: accept edge at cycle T. CALC spans T+1..T+ITER, FIX is T+ITER+1, valid_o rises at T+ITER+2. With XLEN=32 and BPC=1, that is 34 cycles.
- Fast paths: accept, then go directly to FIX, so valid_o rises at T+2.
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = op_a.
  - Signed overflow (DIV/REM with op_a = most-negative, op_b = -1): quotient = op_a, remainder = 0.
- Flush: flush_i=1 in any state moves to IDLE at the next edge and clears valid_o. No result is produced and no handshake is needed. A request presented in the same cycle as flush_i is not accepted. A flush in DONE discards an unconsumed result.
- Flush and ready_i both high in DONE: go to IDLE; the result counts as consumed.
- funct3 and operands are ignored whenever the unit is not accepting.

Test Plan:
- MUL 7 × 0xFFFFFFFD (XLEN=32, BPC=1), accept at T -> valid_o at T+34, result_o=0xFFFFFFEB; busy_o high T+1..T+34.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU with the same operands -> 0x40000000. MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. Repeat with BPC=2 and BPC=4: same values; latency 18 and 10 cycles respectively.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, both at T+2. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0 at T+2.
- flush_i at T+10 during CALC -> IDLE at T+11, valid_o never asserted, ready_o=1 at T+11. rst_i at T+5 -> all outputs at reset values at T+6.
- Hold ready_i=0 for 5 cycles in DONE -> valid_o, result_o and rd_o stable. With ready_i=1 and a new valid_i waiting -> next accept occurs exactly one IDLE cycle later.
